load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle RV32I load/store unit for the CPU datapath. Takes one decoded LOAD/STORE (base, imm, funct3)
//  and computes the effective address. Runs a valid/ready request and a valid response against a word-wide
//  data memory, then returns sign/zero-extended load data for register writeback.
//  Byte and halfword lanes, strobes and extension are handled here, not in the core.
// PARAMETERS
//  XLEN        32   datapath width; only 32 is supported, checked at elaboration
//  ADDR_W      32   byte-address width; mem_addr is the word address, ADDR_W-2 bits
//  REG_AW      5    destination register index width
//  RSP_TIMEOUT 255  max WAIT cycles before a load faults; 0 disables the timeout
// PORTS
//  clk            in   1         clock
//  reset          in   1         synchronous, active-high
//  req_valid      in   1         operation offered
//  req_ready      out  1         unit idle, can accept
//  req_is_store   in   1         1=store (S-type), 0=load (I-type LOAD)
//  req_funct3     in   3         LB/LH/LW/LBU/LHU or SB/SH/SW
//  req_base       in   XLEN      regs[rs1]
//  req_imm        in   XLEN      sign-extended immediate
//  req_wdata      in   XLEN      regs[rs2] (stores)
//  req_rd         in   REG_AW    load destination
//  mem_req_valid  out  1         memory request
//  mem_req_ready  in   1         memory accepts request
//  mem_we         out  1         1=write
//  mem_addr       out  ADDR_W-2  word address = ea[ADDR_W-1:2]
//  mem_wstrb      out  XLEN/8    byte-lane write enables
//  mem_wdata      out  XLEN      lane-replicated store data
//  mem_rsp_valid  in   1         read data valid
//  mem_rdata      in   XLEN      read word
//  done           out  1         1-cycle pulse: operation finished (load, store or fault)
//  wb_valid       out  1         write wb_data to regs[wb_rd]
//  wb_rd          out  REG_AW    writeback index
//  wb_data        out  XLEN      extended load result
//  fault          out  1         qualifies done: op aborted, no writeback
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; mem_req_valid=0, done=0, wb_valid=0, fault=0; all data outputs 0.
//  Reset mid-operation aborts. A mem_rsp_valid that arrives while in IDLE is ignored.
//  States:
//   - IDLE: req_ready=1. On req_valid&&req_ready, register ea=(base+imm) mod 2^ADDR_W, funct3, rd, wdata.
//   - Next state: ISSUE, or DONE with fault=1 if funct3 is illegal (011, 110, 111; any store funct3 >010).
//   - ISSUE: mem_req_valid=1, with addr/we/wstrb/wdata held stable until mem_req_ready.
//     On handshake: a store goes to DONE; a load goes to WAIT.
//   - WAIT: load only. On mem_rsp_valid, extract lane into wb_data and go to DONE.
//     A response in the same cycle as the ISSUE handshake is not accepted.
//   - WAIT timeout: a counter runs while in WAIT. Reaching RSP_TIMEOUT (if nonzero) means DONE with fault=1.
//   - DONE: done=1 for exactly one cycle, then IDLE. wb_valid=1 only for a non-faulting load with rd!=0.
//  Minimum latency, mem ready/rsp immediate: store accept->done 2 cycles; load accept->done 3 cycles.
//  Load extract: byte = rdata[8*ea[1:0]+:8]; half = rdata[16*ea[1]+:16]. LB/LH sign-extend; LBU/LHU zero-extend.
//  Store: SB wstrb=4'b0001<<ea[1:0], wdata={4{b}}; SH wstrb=4'b0011<<(2*ea[1]), wdata={2{h}}; SW wstrb=4'hF.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with ea[0]!=0, or word with ea[1:0]!=0, goes IDLE->DONE with fault=1.
//   No memory request is made and no writeback occurs.
//  LSU_MISALIGN_TRAP_EN undefined: misalignment is ignored. Word access uses ea aligned down.
//   Half access uses lane ea[1]. fault comes only from illegal funct3 or timeout.
// STRUCTURE
//  lsu_pkg: funct3 constants (F3_B/H/W/BU/HU), OPCODE_LOAD/OPCODE_STORE, lsu_state_t enum (IDLE, ISSUE, WAIT, DONE).
//  Sub-module lsu_lane_align (combinational): wstrb/wdata generation and load extract/extend.
//  The FSM, timeout counter and holding registers stay in load_store_unit.
// TESTING
//  - SW base=0x100 imm=4 wdata=0xDEADBEEF, ready=1 -> mem_addr=0x41, wstrb=F, wdata=DEADBEEF; done 2 cycles after accept.
//  - SB ea=0x103 data=0x5A -> wstrb=4'b1000, wdata=0x5A5A5A5A; SH ea=0x102 -> wstrb=4'b1100.
//  - rdata=0x80F17F80, ea low=01: LB -> wb_data=0x0000007F. LBU at ea=11 -> 0x00000080. LH at ea=10 -> 0xFFFF80F1.
//  - mem_req_ready low 5 cycles -> mem_req_valid/addr stable, req_ready=0; then load rd=0 -> done=1, wb_valid=0.
//  - LW ea=0x102: with macro, fault=1, no mem_req_valid. Without macro, mem_addr=0x40, full word returned.
//  - No rsp for 255 WAIT cycles -> done+fault. Reset asserted in WAIT -> IDLE, req_ready=1 next cycle; late rsp ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings, opcodes,
// FSM state type and funct3/alignment classification helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] ea_lo);
    return ((f3[1:0] == 2'b01) && ea_lo[0]) || ((f3[1:0] == 2'b10) && (ea_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane steering: store strobe and data replication, load lane
// extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    unique case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << ea_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << {ea_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb = 4'hF;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    rbyte = 8'(load_word >> {ea_lo, 3'b000});
    rhalf = 16'(load_word >> {ea_lo[1], 4'b0000});
    unique case (funct3)
      F3_B:    load_data = {{24{rbyte[7]}}, rbyte};
      F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
      F3_BU:   load_data = {24'd0, rbyte};
      F3_HU:   load_data = {16'd0, rhalf};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit (IDLE -> ISSUE -> WAIT -> DONE).
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses without a memory request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          ADDR_W      = 32,
  parameter int          REG_AW      = 5,
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_base,
  input  logic [XLEN-1:0]   req_imm,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [REG_AW-1:0] req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              done,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              fault
);

  if (XLEN != 32) begin : g_xlen_check
    $error("load_store_unit supports XLEN=32 only");
  end

  localparam int               CW      = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam bit               TO_EN   = (RSP_TIMEOUT != 0);
  localparam logic [CW-1:0]    TO_LAST = CW'(RSP_TIMEOUT - 1);

  lsu_state_t        state;
  logic [ADDR_W-1:0] ea_q;
  logic [2:0]        f3_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   wdata_q;
  logic              is_store_q;
  logic              fault_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [CW-1:0]     cnt;

  logic [XLEN-1:0]   sum;
  logic [ADDR_W-1:0] ea_next;
  logic              bad_req;
  logic [3:0]        lane_strb;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_ldata;

  always_comb begin
    sum     = req_base + req_imm;
    ea_next = sum[ADDR_W-1:0];
    bad_req = !f3_legal(req_is_store, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    bad_req = bad_req || misaligned(req_funct3, ea_next[1:0]);
`endif
  end

  lsu_lane_align u_lane_align (
    .funct3     (f3_q),
    .ea_lo      (ea_q[1:0]),
    .store_data (wdata_q),
    .load_word  (mem_rdata),
    .wstrb      (lane_strb),
    .wdata      (lane_wdata),
    .load_data  (lane_ldata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ea_q       <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      wdata_q    <= '0;
      is_store_q <= 1'b0;
      fault_q    <= 1'b0;
      wb_data_q  <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          ea_q       <= ea_next;
          f3_q       <= req_funct3;
          rd_q       <= req_rd;
          wdata_q    <= req_wdata;
          is_store_q <= req_is_store;
          fault_q    <= bad_req;
          cnt        <= '0;
          state      <= bad_req ? DONE : ISSUE;
        end
        ISSUE: if (mem_req_ready) begin
          cnt   <= '0;
          state <= is_store_q ? DONE : WAIT;
        end
        // Response wins over timeout when both land in the same cycle.
        WAIT: begin
          if (mem_rsp_valid) begin
            wb_data_q <= lane_ldata;
            state     <= DONE;
          end else if (TO_EN && (cnt == TO_LAST)) begin
            fault_q <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready     = (state == IDLE);
    mem_req_valid = (state == ISSUE);
    mem_we        = mem_req_valid && is_store_q;
    mem_addr      = mem_req_valid ? ea_q[ADDR_W-1:2] : '0;
    mem_wstrb     = mem_we ? lane_strb : '0;
    mem_wdata     = mem_we ? lane_wdata : '0;
    done          = (state == DONE);
    fault         = done && fault_q;
    wb_valid      = done && !fault_q && !is_store_q && (rd_q != '0);
    wb_rd         = rd_q;
    wb_data       = wb_data_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_imm;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        done;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.XLEN(32), .ADDR_W(32), .REG_AW(5), .RSP_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .done(done), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request; returns just after the accepting edge.
  task automatic offer(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] wd, input logic [4:0] rd);
    req_is_store = st;
    req_funct3   = f3;
    req_base     = base;
    req_imm      = imm;
    req_wdata    = wd;
    req_rd       = rd;
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
  endtask

  // Load with immediate ready and response; checks the writeback.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] ea,
                         input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
    offer(1'b0, f3, ea, 32'd0, 32'd0, rd);
    mem_req_ready = 1'b1;
    tick();
    mem_rsp_valid = 1'b1;
    mem_rdata     = rdata;
    tick();
    mem_rsp_valid = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check({tag, "_data"}, wb_data, exp);
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_base = '0; req_imm = '0; req_wdata = '0; req_rd = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;

    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mreq", {31'd0, mem_req_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_addr", {2'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);

    // SW: ISSUE the cycle after accept, DONE the cycle after that
    offer(1'b1, 3'b010, 32'h100, 32'd4, 32'hDEADBEEF, 5'd0);
    check("sw_mreq", {31'd0, mem_req_valid}, 32'd1);
    check("sw_we", {31'd0, mem_we}, 32'd1);
    check("sw_addr", {2'd0, mem_addr}, 32'h41);
    check("sw_strb", {28'd0, mem_wstrb}, 32'hF);
    check("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_done_early", {31'd0, done}, 32'd0);
    tick();
    check("sw_done", {31'd0, done}, 32'd1);
    check("sw_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    check("sw_idle", {31'd0, req_ready}, 32'd1);

    offer(1'b1, 3'b000, 32'h100, 32'd3, 32'h1234565A, 5'd0);
    check("sb_strb", {28'd0, mem_wstrb}, 32'h8);
    check("sb_wdata", mem_wdata, 32'h5A5A5A5A);
    tick(); tick();

    offer(1'b1, 3'b001, 32'h100, 32'd2, 32'hABCD1234, 5'd0);
    check("sh_strb", {28'd0, mem_wstrb}, 32'hC);
    check("sh_wdata", mem_wdata, 32'h12341234);
    tick(); tick();

    do_load("lb", 3'b000, 32'h101, 5'd5, 32'h80F17F80, 32'h0000007F);
    do_load("lbu", 3'b100, 32'h103, 5'd6, 32'h80F17F80, 32'h00000080);
    do_load("lh", 3'b001, 32'h102, 5'd7, 32'h80F17F80, 32'hFFFF80F1);
    do_load("lhu", 3'b101, 32'h102, 5'd8, 32'h80F17F80, 32'h000080F1);
    do_load("lb0", 3'b000, 32'h100, 5'd9, 32'h80F17F80, 32'hFFFFFF80);

    // Stall for 5 cycles, response offered during the ISSUE handshake must be ignored
    mem_req_ready = 1'b0;
    offer(1'b0, 3'b010, 32'h200, 32'd8, 32'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      check("stall_mreq", {31'd0, mem_req_valid}, 32'd1);
      check("stall_addr", {2'd0, mem_addr}, 32'h82);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hBAD0BAD0;
    tick();
    check("hs_rsp_ignored", {31'd0, done}, 32'd0);
    mem_rdata = 32'h01020304;
    tick();
    mem_rsp_valid = 1'b0;
    check("rd0_done", {31'd0, done}, 32'd1);
    check("rd0_wbv", {31'd0, wb_valid}, 32'd0);
    check("rd0_fault", {31'd0, fault}, 32'd0);
    check("rd0_data", wb_data, 32'h01020304);
    tick();

    // Misaligned LW
`ifdef LSU_MISALIGN_TRAP_EN
    offer(1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 5'd4);
    check("mis_done", {31'd0, done}, 32'd1);
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_mreq", {31'd0, mem_req_valid}, 32'd0);
    check("mis_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
`else
    offer(1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 5'd4);
    check("mis_addr", {2'd0, mem_addr}, 32'h40);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h11223344;
    tick();
    mem_rsp_valid = 1'b0;
    check("mis_fault", {31'd0, fault}, 32'd0);
    check("mis_data", wb_data, 32'h11223344);
    tick();
`endif

    // Illegal funct3: straight to DONE with fault, no request
    offer(1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 5'd2);
    check("ill_ld_fault", {31'd0, fault}, 32'd1);
    check("ill_ld_mreq", {31'd0, mem_req_valid}, 32'd0);
    check("ill_ld_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    offer(1'b1, 3'b100, 32'h100, 32'd0, 32'd0, 5'd0);
    check("ill_st_fault", {31'd0, fault}, 32'd1);
    check("ill_st_done", {31'd0, done}, 32'd1);
    tick();

    // Timeout: 255 WAIT cycles without response
    offer(1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 5'd3);
    tick();
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    check("to_cycles", n, 32'd255);
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_wbv", {31'd0, wb_valid}, 32'd0);
    tick();

    // Reset in WAIT, then a late response must be ignored
    offer(1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 5'd3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rstw_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hCAFEF00D;
    tick();
    mem_rsp_valid = 1'b0;
    check("late_done", {31'd0, done}, 32'd0);
    check("late_wbv", {31'd0, wb_valid}, 32'd0);
    check("late_ready", {31'd0, req_ready}, 32'd1);
    check("late_wbdata", wb_data, 32'd0);
    tick();
    check("late_done2", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
